dlx_fetch_unit: RTL and testbench
=================================

Name: dlx_fetch_unit

Overview:
- Bus-master fetch controller that sits directly upstream of the instruction register environment.
- On a START request from the control sequencer, it reads one 32-bit instruction word from memory at PC using a request/acknowledge handshake.
- It presents the captured word on DI_OUT and pulses IRCE so the instruction register loads it.
- It detects misaligned addresses and handles memory timeouts with bounded retry.

Parameters:
TIMEOUT, 8, WAIT cycles allowed per attempt before abandoning it (≥2)
MAX_RETRY, 2, extra attempts after the first timeout before declaring error (≥0)

Ports:
CLK  in  1  rising-edge clock
RESET_N  in  1  asynchronous active-low reset
START  in  1  fetch request, sampled in IDLE or ERR only
PC  in  32  fetch byte address, sampled with START
MDI  in  32  memory read data, valid when ACK=1
ACK  in  1  memory acknowledge, sampled only in WAIT
MREQ  out  1  memory read request
MADDR  out  32  registered fetch address
DI_OUT  out  32  captured instruction word, drives IR data input
IRCE  out  1  IR clock enable, one-cycle pulse
BUSY  out  1  high in WAIT, GAP and LOAD
DONE  out  1  one-cycle pulse, coincident with IRCE
ERR  out  1  sticky error flag
ERR_CODE  out  2  00 none, 01 misaligned, 10 timeout

Behaviour:
- Reset behaviour:
  - RESET_N low forces state IDLE immediately, independent of CLK.
  - All outputs are 0; MADDR and DI_OUT are 0; the attempt counter and retry counter are 0.
  - Reset mid-fetch aborts with no IRCE pulse.
  - Fetch activity resumes only on a new START after RESET_N is deasserted.
- All outputs are registered (Moore); none are combinational from inputs.
- States: IDLE, WAIT, GAP, LOAD, ERR.
- IDLE, START=1:
  - MADDR is loaded with PC.
  - If PC[1:0]≠00, go to ERR with ERR_CODE=01; MREQ is never asserted.
  - Otherwise go to WAIT: attempt counter=0, retry counter=0, ERR=0, ERR_CODE=00.
- WAIT:
  - MREQ=1 throughout; the attempt counter increments each cycle.
  - ACK=1 sampled: DI_OUT is loaded with MDI, go to LOAD; MREQ=0 from the next cycle.
  - If ACK=0 and the attempt counter = TIMEOUT-1:
    - If retry counter < MAX_RETRY: go to GAP, increment retry counter.
    - Otherwise: go to ERR with ERR_CODE=10.
  - If ACK and timeout coincide on the same edge, ACK wins.
- GAP:
  - Exactly one cycle with MREQ=0; ACK is ignored.
  - Return to WAIT with attempt counter=0; MADDR is unchanged.
- LOAD:
  - IRCE=1 and DONE=1 for exactly this cycle; DI_OUT is stable.
  - Next state is IDLE; START in LOAD is ignored (not queued).
- ERR:
  - ERR=1 held; MREQ=0.
  - START=1 clears ERR and ERR_CODE and behaves exactly as START in IDLE (alignment check included).
- DI_OUT holds the last captured word until the next successful capture; it is not cleared on error.
- START in WAIT or GAP is ignored.
- ACK outside WAIT is ignored.
- Latency:
  - START sampled at edge k: MREQ=1 during cycle k+1.
  - ACK sampled at edge k+1 (earliest): IRCE=1 during cycle k+2.
  - Successful fetch = 2 + (ACK wait cycles) cycles.
- Worst-case error latency: (MAX_RETRY+1)·TIMEOUT + MAX_RETRY + 1 cycles from START to ERR.
- IRCE and DONE never assert in the same cycle as ERR.
- Both counters are sized ≥ ceil(log2(max(TIMEOUT, MAX_RETRY+1)))+1 bits; no wrap occurs within legal parameter range.

Test Plan:
1. PC=0x00000010, START one cycle, ACK with MDI=0x8C010011 on the third WAIT cycle → MADDR=0x00000010, MREQ high 3 cycles, DI_OUT=0x8C010011, IRCE=DONE=1 for exactly 1 cycle, 4 cycles after START edge, then IDLE.
2. PC=0x00000012, START → next cycle ERR=1, ERR_CODE=01, MREQ stays 0; then START with PC=0x00000014 and immediate ACK, MDI=0x00432023 → ERR clears, IRCE pulses, DI_OUT=0x00432023.
3. TIMEOUT=4, MAX_RETRY=1, ACK held 0 → MREQ high 4 cycles, low 1 (GAP), high 4, then ERR=1 with ERR_CODE=10 at cycle 10; IRCE never asserts.
4. ACK asserted on the same edge as the first timeout → capture wins: DI_OUT=MDI, IRCE pulse, no GAP.
5. RESET_N pulled low asynchronously mid-WAIT → MREQ, BUSY and IRCE drop to 0 without waiting for CLK edge; a later ACK=1 with no START produces no IRCE.
6. START held high continuously, ACK immediate → fetches at every 3rd cycle (IDLE, WAIT, LOAD); START during LOAD is not double-counted; exactly one IRCE per fetch.

Source files
------------

// File: rtl/dlx_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : dlx_fetch_unit
// Purpose  : Instruction fetch bus master. It reads one 32-bit word at PC
//            through a request/acknowledge handshake and pulses IRCE to load
//            the instruction register. It flags misaligned PCs and retries
//            on memory timeouts, up to a fixed limit.
// Revision : 1.0 - initial release
// ============================================================================
module dlx_fetch_unit #(
    parameter int TIMEOUT   = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [31:0] PC,
    input  logic [31:0] MDI,
    input  logic        ACK,
    output logic        MREQ,
    output logic [31:0] MADDR,
    output logic [31:0] DI_OUT,
    output logic        IRCE,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [1:0]  ERR_CODE
);

    localparam int c_CNT_MAX = (TIMEOUT > MAX_RETRY + 1) ? TIMEOUT : MAX_RETRY + 1;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX) + 1;

    localparam logic [c_CNT_W-1:0] c_CNT_ZERO     = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_ATTEMPT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_RETRY_LIMIT  = c_CNT_W'(MAX_RETRY);

    localparam logic [1:0] c_CODE_NONE     = 2'b00;
    localparam logic [1:0] c_CODE_MISALIGN = 2'b01;
    localparam logic [1:0] c_CODE_TIMEOUT  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_GAP  = 3'd2,
        S_LOAD = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [c_CNT_W-1:0] r_attempt;
    logic [c_CNT_W-1:0] w_next_attempt;
    logic [c_CNT_W-1:0] r_retry;
    logic [c_CNT_W-1:0] w_next_retry;
    logic [31:0]        r_maddr;
    logic [31:0]        w_next_maddr;
    logic [31:0]        r_di;
    logic [31:0]        w_next_di;
    logic [1:0]         r_err_code;
    logic [1:0]         w_next_err_code;

    logic               r_mreq;
    logic               r_busy;
    logic               r_irce;
    logic               r_done;
    logic               r_err;
    logic               w_next_mreq;
    logic               w_next_busy;
    logic               w_next_load;
    logic               w_next_err;

    // Next-state and datapath decisions
    always_comb begin
        w_next_state    = r_state;
        w_next_attempt  = r_attempt;
        w_next_retry    = r_retry;
        w_next_maddr    = r_maddr;
        w_next_di       = r_di;
        w_next_err_code = r_err_code;

        case (r_state)
            S_IDLE, S_ERR: begin
                if (START) begin
                    w_next_maddr = PC;
                    if (PC[1:0] != 2'b00) begin
                        w_next_state    = S_ERR;
                        w_next_err_code = c_CODE_MISALIGN;
                    end else begin
                        w_next_state    = S_WAIT;
                        w_next_attempt  = c_CNT_ZERO;
                        w_next_retry    = c_CNT_ZERO;
                        w_next_err_code = c_CODE_NONE;
                    end
                end
            end
            S_WAIT: begin
                // An acknowledge on the timeout edge still counts as a capture.
                if (ACK) begin
                    w_next_di    = MDI;
                    w_next_state = S_LOAD;
                end else if (r_attempt == c_ATTEMPT_LAST) begin
                    if (r_retry < c_RETRY_LIMIT) begin
                        w_next_state = S_GAP;
                        w_next_retry = r_retry + c_CNT_ONE;
                    end else begin
                        w_next_state    = S_ERR;
                        w_next_err_code = c_CODE_TIMEOUT;
                    end
                end else begin
                    w_next_attempt = r_attempt + c_CNT_ONE;
                end
            end
            S_GAP: begin
                w_next_state   = S_WAIT;
                w_next_attempt = c_CNT_ZERO;
            end
            S_LOAD: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they leave flops directly.
    always_comb begin
        w_next_mreq = (w_next_state == S_WAIT);
        w_next_busy = (w_next_state == S_WAIT) || (w_next_state == S_GAP) ||
                      (w_next_state == S_LOAD);
        w_next_load = (w_next_state == S_LOAD);
        w_next_err  = (w_next_state == S_ERR);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= S_IDLE;
            r_attempt  <= c_CNT_ZERO;
            r_retry    <= c_CNT_ZERO;
            r_maddr    <= 32'h0;
            r_di       <= 32'h0;
            r_err_code <= c_CODE_NONE;
            r_mreq     <= 1'b0;
            r_busy     <= 1'b0;
            r_irce     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_attempt  <= w_next_attempt;
            r_retry    <= w_next_retry;
            r_maddr    <= w_next_maddr;
            r_di       <= w_next_di;
            r_err_code <= w_next_err_code;
            r_mreq     <= w_next_mreq;
            r_busy     <= w_next_busy;
            r_irce     <= w_next_load;
            r_done     <= w_next_load;
            r_err      <= w_next_err;
        end
    end

    assign MREQ     = r_mreq;
    assign MADDR    = r_maddr;
    assign DI_OUT   = r_di;
    assign IRCE     = r_irce;
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign ERR      = r_err;
    assign ERR_CODE = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_dlx_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_dlx_fetch_unit
// Purpose  : Directed vector bench for dlx_fetch_unit (TIMEOUT=4, MAX_RETRY=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dlx_fetch_unit;

    logic        CLK;
    logic        RESET_N;
    logic        START;
    logic [31:0] PC;
    logic [31:0] MDI;
    logic        ACK;
    logic        MREQ;
    logic [31:0] MADDR;
    logic [31:0] DI_OUT;
    logic        IRCE;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [1:0]  ERR_CODE;

    dlx_fetch_unit #(
        .TIMEOUT   (4),
        .MAX_RETRY (1)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .START    (START),
        .PC       (PC),
        .MDI      (MDI),
        .ACK      (ACK),
        .MREQ     (MREQ),
        .MADDR    (MADDR),
        .DI_OUT   (DI_OUT),
        .IRCE     (IRCE),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR),
        .ERR_CODE (ERR_CODE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Flag groups {MREQ, BUSY, IRCE, DONE, ERR}
    localparam logic [4:0] F_IDLE = 5'b00000;
    localparam logic [4:0] F_WAIT = 5'b11000;
    localparam logic [4:0] F_GAP  = 5'b01000;
    localparam logic [4:0] F_LOAD = 5'b01110;
    localparam logic [4:0] F_ERR  = 5'b00001;

    typedef struct {
        string       name;
        logic        start;
        logic [31:0] pc;
        logic        ack;
        logic [31:0] mdi;
        logic [4:0]  e_flags;
        logic [1:0]  e_code;
        logic [31:0] e_maddr;
        logic [31:0] e_di;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input string nm, input logic s, input logic [31:0] p,
                       input logic a, input logic [31:0] m, input logic [4:0] f,
                       input logic [1:0] c, input logic [31:0] ma, input logic [31:0] di);
        vec_t v;
        v.name = nm; v.start = s; v.pc = p; v.ack = a; v.mdi = m;
        v.e_flags = f; v.e_code = c; v.e_maddr = ma; v.e_di = di;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string nm, input logic [4:0] f, input logic [1:0] c,
                         input logic [31:0] ma, input logic [31:0] di);
        logic [70:0] got;
        logic [70:0] exp;
        got = {MREQ, BUSY, IRCE, DONE, ERR, ERR_CODE, MADDR, DI_OUT};
        exp = {f, c, ma, di};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got flags=%b code=%b maddr=%h di=%h, expected flags=%b code=%b maddr=%h di=%h",
                     nm, got[70:66], got[65:64], got[63:32], got[31:0], f, c, ma, di);
        end
    endtask

    initial begin
        // Plan 1: aligned fetch, ACK on the third WAIT cycle
        add("t1_start", 1, 32'h10, 0, 32'h0,        F_WAIT, 2'b00, 32'h10, 32'h0);
        add("t1_wait2", 0, 32'h0,  0, 32'h0,        F_WAIT, 2'b00, 32'h10, 32'h0);
        add("t1_wait3", 0, 32'h0,  0, 32'h0,        F_WAIT, 2'b00, 32'h10, 32'h0);
        add("t1_load",  0, 32'h0,  1, 32'h8C010011, F_LOAD, 2'b00, 32'h10, 32'h8C010011);
        add("t1_idle",  0, 32'h0,  0, 32'h0,        F_IDLE, 2'b00, 32'h10, 32'h8C010011);
        // Plan 2: misaligned PC, then recovery from ERR
        add("t2_misal", 1, 32'h12, 0, 32'h0,        F_ERR,  2'b01, 32'h12, 32'h8C010011);
        add("t2_hold",  0, 32'h0,  1, 32'h11111111, F_ERR,  2'b01, 32'h12, 32'h8C010011);
        add("t2_restart",1,32'h14, 0, 32'h0,        F_WAIT, 2'b00, 32'h14, 32'h8C010011);
        add("t2_load",  0, 32'h0,  1, 32'h00432023, F_LOAD, 2'b00, 32'h14, 32'h00432023);
        add("t2_idle",  0, 32'h0,  0, 32'h0,        F_IDLE, 2'b00, 32'h14, 32'h00432023);
        // Plan 3: ACK never arrives: WAIT x4, GAP, WAIT x4, ERR timeout
        add("t3_w1",    1, 32'h20, 0, 32'h0,        F_WAIT, 2'b00, 32'h20, 32'h00432023);
        add("t3_w2",    0, 32'h0,  0, 32'h0,        F_WAIT, 2'b00, 32'h20, 32'h00432023);
        add("t3_w3",    0, 32'h0,  0, 32'h0,        F_WAIT, 2'b00, 32'h20, 32'h00432023);
        add("t3_w4",    0, 32'h0,  0, 32'h0,        F_WAIT, 2'b00, 32'h20, 32'h00432023);
        add("t3_gap",   0, 32'h0,  0, 32'h0,        F_GAP,  2'b00, 32'h20, 32'h00432023);
        add("t3_gapack",0, 32'h0,  1, 32'hDEADBEEF, F_WAIT, 2'b00, 32'h20, 32'h00432023);
        add("t3_w6",    0, 32'h0,  0, 32'h0,        F_WAIT, 2'b00, 32'h20, 32'h00432023);
        add("t3_wstart",1, 32'h40, 0, 32'h0,        F_WAIT, 2'b00, 32'h20, 32'h00432023);
        add("t3_w8",    0, 32'h0,  0, 32'h0,        F_WAIT, 2'b00, 32'h20, 32'h00432023);
        add("t3_err",   0, 32'h0,  0, 32'h0,        F_ERR,  2'b10, 32'h20, 32'h00432023);
        add("t3_hold",  0, 32'h0,  0, 32'h0,        F_ERR,  2'b10, 32'h20, 32'h00432023);
        // Plan 4: ACK coincides with the first timeout edge
        add("t4_start", 1, 32'h30, 0, 32'h0,        F_WAIT, 2'b00, 32'h30, 32'h00432023);
        add("t4_w2",    0, 32'h0,  0, 32'h0,        F_WAIT, 2'b00, 32'h30, 32'h00432023);
        add("t4_w3",    0, 32'h0,  0, 32'h0,        F_WAIT, 2'b00, 32'h30, 32'h00432023);
        add("t4_w4",    0, 32'h0,  0, 32'h0,        F_WAIT, 2'b00, 32'h30, 32'h00432023);
        add("t4_load",  0, 32'h0,  1, 32'h12345678, F_LOAD, 2'b00, 32'h30, 32'h12345678);
        add("t4_idle",  0, 32'h0,  0, 32'h0,        F_IDLE, 2'b00, 32'h30, 32'h12345678);
        // Plan 6: START held, ACK held: one fetch every three cycles
        add("t6_w_a",   1, 32'h40, 1, 32'hAAAA0001, F_WAIT, 2'b00, 32'h40, 32'h12345678);
        add("t6_l_a",   1, 32'h40, 1, 32'hAAAA0001, F_LOAD, 2'b00, 32'h40, 32'hAAAA0001);
        add("t6_i_a",   1, 32'h40, 1, 32'hAAAA0002, F_IDLE, 2'b00, 32'h40, 32'hAAAA0001);
        add("t6_w_b",   1, 32'h40, 1, 32'hAAAA0002, F_WAIT, 2'b00, 32'h40, 32'hAAAA0001);
        add("t6_l_b",   1, 32'h40, 1, 32'hAAAA0002, F_LOAD, 2'b00, 32'h40, 32'hAAAA0002);
        add("t6_i_b",   0, 32'h0,  0, 32'h0,        F_IDLE, 2'b00, 32'h40, 32'hAAAA0002);

        RESET_N = 1'b0;
        START   = 1'b0;
        PC      = 32'h0;
        MDI     = 32'h0;
        ACK     = 1'b0;
        tick();
        tick();
        check("reset", F_IDLE, 2'b00, 32'h0, 32'h0);
        RESET_N = 1'b1;
        tick();
        check("post_reset_idle", F_IDLE, 2'b00, 32'h0, 32'h0);

        foreach (vecs[i]) begin
            START = vecs[i].start;
            PC    = vecs[i].pc;
            ACK   = vecs[i].ack;
            MDI   = vecs[i].mdi;
            tick();
            check(vecs[i].name, vecs[i].e_flags, vecs[i].e_code, vecs[i].e_maddr, vecs[i].e_di);
        end

        // Plan 5: asynchronous reset in the middle of WAIT
        START = 1'b1; PC = 32'h50; ACK = 1'b0; MDI = 32'h0;
        tick();
        START = 1'b0;
        check("t5_wait", F_WAIT, 2'b00, 32'h50, 32'hAAAA0002);
        #3;
        RESET_N = 1'b0;
        #1;
        check("t5_async_drop", F_IDLE, 2'b00, 32'h0, 32'h0);
        RESET_N = 1'b1;
        ACK = 1'b1; MDI = 32'hFFFFFFFF;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t5_no_fetch", F_IDLE, 2'b00, 32'h0, 32'h0);
        end
        ACK = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
